// File: rtl/rx78_pixel_pipe.sv
// Pixel stage: fetches six 1bpp planes from VRAM, serialises them and resolves
// fg/bg priority, plane masks and palette bytes into 8-bit RGB.
module rx78_pixel_pipe #(
    parameter logic [8:0]  H_START = 9'd64,
    parameter logic [8:0]  V_START = 9'd24,
    parameter int unsigned H_PIX   = 192,
    parameter int unsigned V_LINES = 184
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  h,
    input  logic [8:0]  v,
    input  logic        hb,
    input  logic        vb,
    output logic [12:0] vdp_addr,
    input  logic [7:0]  fg1,
    input  logic [7:0]  fg2,
    input  logic [7:0]  fg3,
    input  logic [7:0]  bg1,
    input  logic [7:0]  bg2,
    input  logic [7:0]  bg3,
    input  logic [7:0]  p1,
    input  logic [7:0]  p2,
    input  logic [7:0]  p3,
    input  logic [7:0]  p4,
    input  logic [7:0]  p5,
    input  logic [7:0]  p6,
    input  logic [7:0]  mask,
    input  logic [7:0]  cmask,
    input  logic [7:0]  bgc,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue
);

    localparam logic [9:0] HS     = {1'b0, H_START};
    localparam logic [9:0] HE     = HS + 10'(H_PIX);
    localparam logic [9:0] FETCH0 = HS - 10'd2;
    localparam logic [9:0] LOAD0  = HS - 10'd1;
    localparam logic [9:0] VS     = {1'b0, V_START};
    localparam logic [9:0] VE     = VS + 10'(V_LINES);
    localparam logic [9:0] PIX    = 10'(H_PIX);
    localparam logic [8:0] V_CLR  = V_START - 9'd1;

    logic [9:0] h10, v10, fetch_off, load_off;
    logic       line_act, px_act, fetch_pt, load_pt;

    assign h10       = {1'b0, h};
    assign v10       = {1'b0, v};
    assign fetch_off = h10 - FETCH0;
    assign load_off  = h10 - LOAD0;
    assign line_act  = (v10 >= VS) && (v10 < VE);
    assign px_act    = line_act && (h10 >= HS) && (h10 < HE);
    assign fetch_pt  = line_act && (h10 >= FETCH0) && (fetch_off < PIX) &&
                       (fetch_off[2:0] == 3'd0);
    assign load_pt   = line_act && (h10 >= LOAD0) && (load_off < PIX) &&
                       (load_off[2:0] == 3'd0);

    logic [12:0] row_base_q, row_base_d;
    logic [4:0]  fetch_cnt_q, fetch_cnt_d;
    logic [12:0] vdp_addr_q, vdp_addr_d;

    // Row base advances by addition only, one line stride per finished line.
    always_comb begin
        row_base_d  = row_base_q;
        fetch_cnt_d = fetch_cnt_q;
        vdp_addr_d  = vdp_addr_q;
        if (v == V_CLR) begin
            row_base_d = 13'd0;
        end else if (line_act && (h10 == HE)) begin
            row_base_d = row_base_q + 13'd24;
        end
        if (fetch_pt) begin
            vdp_addr_d  = row_base_q + {8'd0, fetch_cnt_q};
            fetch_cnt_d = fetch_cnt_q + 5'd1;
        end else if (!line_act || (h10 == HE)) begin
            fetch_cnt_d = 5'd0;
        end
    end

    // Plane shifters: [0..2] = fg1..fg3, [3..5] = bg1..bg3; bit 0 is the current pixel.
    logic [5:0][7:0] sr_q, sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_pt) begin
            sr_d = {bg3, bg2, bg1, fg3, fg2, fg1};
        end else begin
            for (int i = 0; i < 6; i++) begin
                sr_d[i] = {1'b0, sr_q[i][7:1]};
            end
        end
    end

    logic [2:0] fi, bi;
    logic [2:0] rgb_on;
    logic [7:0] red_q, green_q, blue_q;

    assign fi = {sr_q[2][0], sr_q[1][0], sr_q[0][0]} & mask[2:0];
    assign bi = {sr_q[5][0], sr_q[4][0], sr_q[3][0]} & mask[5:3];

    // rgb_on bit 0 = R, 1 = G, 2 = B.
    always_comb begin
        rgb_on = bgc[2:0];
        if (px_act) begin
            if (fi != 3'd0) begin
                rgb_on = {p3[fi] & cmask[2], p2[fi] & cmask[1], p1[fi] & cmask[0]};
            end else if (bi != 3'd0) begin
                rgb_on = {p6[bi] & cmask[5], p5[bi] & cmask[4], p4[bi] & cmask[3]};
            end
        end
        if (hb || vb) begin
            rgb_on = 3'b000;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_base_q  <= 13'd0;
            fetch_cnt_q <= 5'd0;
            vdp_addr_q  <= 13'd0;
            sr_q        <= '0;
            red_q       <= 8'h00;
            green_q     <= 8'h00;
            blue_q      <= 8'h00;
        end else begin
            row_base_q  <= row_base_d;
            fetch_cnt_q <= fetch_cnt_d;
            vdp_addr_q  <= vdp_addr_d;
            sr_q        <= sr_d;
            red_q       <= {8{rgb_on[0]}};
            green_q     <= {8{rgb_on[1]}};
            blue_q      <= {8{rgb_on[2]}};
        end
    end

    assign vdp_addr = vdp_addr_q;
    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;

    logic unused_bits;
    assign unused_bits = ^{bgc[7:3], mask[7:6], cmask[7:6]};

endmodule

// File: tb/tb_rx78_pixel_pipe.sv
// Randomised self-checking bench for rx78_pixel_pipe against a per-pixel model.
module tb_rx78_pixel_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  h, v;
    logic        hb, vb;
    logic [12:0] vdp_addr;
    logic [7:0]  fg1, fg2, fg3, bg1, bg2, bg3;
    logic [7:0]  p1, p2, p3, p4, p5, p6, mask, cmask, bgc;
    logic [7:0]  red, green, blue;

    logic [7:0] m_fg1 [0:8191];
    logic [7:0] m_fg2 [0:8191];
    logic [7:0] m_fg3 [0:8191];
    logic [7:0] m_bg1 [0:8191];
    logic [7:0] m_bg2 [0:8191];
    logic [7:0] m_bg3 [0:8191];

    assign fg1 = m_fg1[vdp_addr];
    assign fg2 = m_fg2[vdp_addr];
    assign fg3 = m_fg3[vdp_addr];
    assign bg1 = m_bg1[vdp_addr];
    assign bg2 = m_bg2[vdp_addr];
    assign bg3 = m_bg3[vdp_addr];

    int n_vec = 0;
    int n_bad = 0;

    logic [23:0] o_rgb  [0:207];
    logic [23:0] e_rgb  [0:207];
    logic [12:0] o_addr [0:207];
    int          e_addr [0:207];

    always #5 clk = ~clk;

    rx78_pixel_pipe dut (
        .clk(clk), .reset(reset), .h(h), .v(v), .hb(hb), .vb(vb), .vdp_addr(vdp_addr),
        .fg1(fg1), .fg2(fg2), .fg3(fg3), .bg1(bg1), .bg2(bg2), .bg3(bg3),
        .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p5(p5), .p6(p6),
        .mask(mask), .cmask(cmask), .bgc(bgc),
        .red(red), .green(green), .blue(blue)
    );

    // Expected colour for a cycle, straight from the picture geometry.
    function automatic logic [23:0] exp_rgb(input int hh, input int vv, input logic hbb,
                                            input logic vbb);
        int x, y, a, b;
        logic [2:0] fidx, bidx;
        logic r, g, bl;
        if (hbb || vbb) return 24'h000000;
        r = bgc[0]; g = bgc[1]; bl = bgc[2];
        if (vv >= 24 && vv < 208 && hh >= 64 && hh < 256) begin
            x = hh - 64; y = vv - 24; a = y * 24 + x / 8; b = x % 8;
            fidx = {m_fg3[a][b], m_fg2[a][b], m_fg1[a][b]} & mask[2:0];
            bidx = {m_bg3[a][b], m_bg2[a][b], m_bg1[a][b]} & mask[5:3];
            if (fidx != 0) begin
                r = p1[fidx] & cmask[0]; g = p2[fidx] & cmask[1]; bl = p3[fidx] & cmask[2];
            end else if (bidx != 0) begin
                r = p4[bidx] & cmask[3]; g = p5[bidx] & cmask[4]; bl = p6[bidx] & cmask[5];
            end
        end
        return {{8{r}}, {8{g}}, {8{bl}}};
    endfunction

    function automatic int exp_addr(input int hh, input int vv);
        if (vv >= 24 && vv < 208 && hh >= 62 && hh <= 246 && (hh - 62) % 8 == 0)
            return (vv - 24) * 24 + (hh - 62) / 8;
        return -1;
    endfunction

    task automatic fill_mem(input int mode);
        for (int a = 0; a < 8192; a++) begin
            m_fg1[a] = (mode == 1) ? 8'hFF : (mode == 2) ? 8'($urandom) : 8'h00;
            m_bg1[a] = (mode == 1) ? 8'hFF : (mode == 2) ? 8'($urandom) : 8'h00;
            m_fg2[a] = (mode == 2) ? 8'($urandom) : 8'h00;
            m_fg3[a] = (mode == 2) ? 8'($urandom) : 8'h00;
            m_bg2[a] = (mode == 2) ? 8'($urandom) : 8'h00;
            m_bg3[a] = (mode == 2) ? 8'($urandom) : 8'h00;
        end
    endtask

    task automatic set_pal_random();
        p1 = 8'($urandom); p2 = 8'($urandom); p3 = 8'($urandom);
        p4 = 8'($urandom); p5 = 8'($urandom); p6 = 8'($urandom);
        mask = 8'($urandom); cmask = 8'($urandom); bgc = 8'($urandom);
    endtask

    task automatic drive(input int hh, input int vv);
        h  = 9'(hh);
        v  = 9'(vv);
        hb = (hh < 58) || (hh >= 260);
        vb = (vv < 22) || (vv >= 209);
    endtask

    // One line, h = 56..263; records observations and model expectations.
    task automatic run_line(input int vv, input bit wobble);
        int hh;
        for (int i = 0; i < 208; i++) begin
            hh = 56 + i;
            @(negedge clk);
            drive(hh, vv);
            if (wobble && $urandom_range(0, 15) == 0) set_pal_random();
            e_rgb[i]  = exp_rgb(hh, vv, hb, vb);
            e_addr[i] = exp_addr(hh, vv);
            @(posedge clk);
            #1;
            o_rgb[i]  = {red, green, blue};
            o_addr[i] = vdp_addr;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        fill_mem(2);
        set_pal_random();
        bgc = 8'h07;
        drive(62, 24);
        @(posedge clk);
        #1;
        n_vec += 4;
        if (vdp_addr !== 13'd0) begin
            n_bad++; $display("FAIL reset_addr got %0d want 0", vdp_addr);
        end
        if (red !== 8'h00) begin n_bad++; $display("FAIL reset_red got %02h want 00", red); end
        if (green !== 8'h00) begin
            n_bad++; $display("FAIL reset_green got %02h want 00", green);
        end
        if (blue !== 8'h00) begin n_bad++; $display("FAIL reset_blue got %02h want 00", blue); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_backdrop();
        fill_mem(0);
        set_pal_random();
        bgc = 8'h01; mask = 8'h3F;
        run_line(21, 0);
        n_vec++;
        if (o_rgb[44] !== 24'h000000) begin
            n_bad++; $display("FAIL backdrop_vb got %06h want 000000", o_rgb[44]);
        end
        for (int vv = 22; vv <= 24; vv++) run_line(vv, 0);
        n_vec += 3;
        if (o_rgb[44] !== 24'hFF0000) begin
            n_bad++; $display("FAIL backdrop_active got %06h want FF0000", o_rgb[44]);
        end
        if (o_rgb[2] !== 24'hFF0000) begin
            n_bad++; $display("FAIL backdrop_border got %06h want FF0000", o_rgb[2]);
        end
        if (o_rgb[206] !== 24'h000000) begin
            n_bad++; $display("FAIL backdrop_hb got %06h want 000000", o_rgb[206]);
        end
    endtask

    task automatic test_single_pixel();
        fill_mem(0);
        m_fg1[0] = 8'h01;
        p1 = 8'h02; p2 = 8'h00; p3 = 8'h00; p4 = 8'h00; p5 = 8'h00; p6 = 8'h00;
        cmask = 8'h3F; mask = 8'h3F; bgc = 8'h06;
        for (int vv = 21; vv <= 24; vv++) run_line(vv, 0);
        n_vec += 2;
        if (o_rgb[8] !== 24'hFF0000) begin
            n_bad++; $display("FAIL pixel00 got %06h want FF0000", o_rgb[8]);
        end
        if (o_rgb[9] !== 24'h00FFFF) begin
            n_bad++; $display("FAIL pixel10 got %06h want 00FFFF", o_rgb[9]);
        end
    endtask

    task automatic test_priority();
        fill_mem(1);
        p1 = 8'h00; p2 = 8'h02; p3 = 8'h00; p4 = 8'h02; p5 = 8'h00; p6 = 8'h00;
        cmask = 8'h3F; mask = 8'h3F; bgc = 8'h04;
        for (int vv = 21; vv <= 24; vv++) run_line(vv, 0);
        n_vec += 3;
        if (o_rgb[8] !== 24'h00FF00) begin
            n_bad++; $display("FAIL prio_fg_first got %06h want 00FF00", o_rgb[8]);
        end
        if (o_rgb[199] !== 24'h00FF00) begin
            n_bad++; $display("FAIL prio_fg_last got %06h want 00FF00", o_rgb[199]);
        end
        if (o_rgb[200] !== 24'h0000FF) begin
            n_bad++; $display("FAIL prio_after_line got %06h want 0000FF", o_rgb[200]);
        end
        mask = 8'h38;
        run_line(25, 0);
        n_vec++;
        if (o_rgb[44] !== 24'hFF0000) begin
            n_bad++; $display("FAIL prio_bg_masked got %06h want FF0000", o_rgb[44]);
        end
    endtask

    task automatic test_addr_trace();
        fill_mem(2);
        set_pal_random();
        for (int vv = 21; vv <= 26; vv++) run_line(vv, 0);
        for (int k = 0; k < 24; k++) begin
            n_vec++;
            if (o_addr[6 + 8 * k] !== 13'(48 + k)) begin
                n_bad++;
                $display("FAIL addr_y2 k=%0d got %0d want %0d", k, o_addr[6 + 8 * k], 48 + k);
            end
        end
        run_line(27, 0);
        n_vec++;
        if (o_addr[6] !== 13'd72) begin
            n_bad++; $display("FAIL addr_y3_first got %0d want 72", o_addr[6]);
        end
    endtask

    task automatic test_cmask_zero();
        fill_mem(1);
        p1 = 8'hFF; p2 = 8'hFF; p3 = 8'hFF; p4 = 8'hFF; p5 = 8'hFF; p6 = 8'hFF;
        cmask = 8'h00; mask = 8'h3F; bgc = 8'h07;
        for (int vv = 21; vv <= 24; vv++) run_line(vv, 0);
        n_vec += 2;
        if (o_rgb[30] !== 24'h000000) begin
            n_bad++; $display("FAIL cmask_zero got %06h want 000000", o_rgb[30]);
        end
        if (o_rgb[201] !== 24'hFFFFFF) begin
            n_bad++; $display("FAIL cmask_backdrop got %06h want FFFFFF", o_rgb[201]);
        end
    endtask

    task automatic test_random();
        for (int pass = 0; pass < 3; pass++) begin
            fill_mem(2);
            set_pal_random();
            for (int vv = 21; vv <= 30; vv++) begin
                run_line(vv, 1);
                for (int i = 0; i < 208; i++) begin
                    n_vec++;
                    if (o_rgb[i] !== e_rgb[i]) begin
                        n_bad++;
                        $display("FAIL rand_rgb v=%0d h=%0d got %06h want %06h",
                                 vv, 56 + i, o_rgb[i], e_rgb[i]);
                    end
                    if (e_addr[i] >= 0) begin
                        n_vec++;
                        if (o_addr[i] !== 13'(e_addr[i])) begin
                            n_bad++;
                            $display("FAIL rand_addr v=%0d h=%0d got %0d want %0d",
                                     vv, 56 + i, o_addr[i], e_addr[i]);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midline();
        fill_mem(2);
        set_pal_random();
        bgc = 8'h07;
        for (int vv = 21; vv <= 24; vv++) run_line(vv, 0);
        for (int hh = 56; hh < 264; hh++) begin
            @(negedge clk);
            drive(hh, 25);
            if (hh == 114) reset = 1'b1;
            if (hh == 120) reset = 1'b0;
            @(posedge clk);
            #1;
            if (hh == 114) begin
                n_vec += 2;
                if ({red, green, blue} !== 24'h000000) begin
                    n_bad++; $display("FAIL midreset_rgb got %06h want 000000", {red, green, blue});
                end
                if (vdp_addr !== 13'd0) begin
                    n_bad++; $display("FAIL midreset_addr got %0d want 0", vdp_addr);
                end
            end
        end
        for (int vv = 21; vv <= 209; vv++) begin
            run_line(vv, 1);
            for (int i = 0; i < 208; i++) begin
                n_vec++;
                if (o_rgb[i] !== e_rgb[i]) begin
                    n_bad++;
                    $display("FAIL frame_rgb v=%0d h=%0d got %06h want %06h",
                             vv, 56 + i, o_rgb[i], e_rgb[i]);
                end
                if (e_addr[i] >= 0) begin
                    n_vec++;
                    if (o_addr[i] !== 13'(e_addr[i])) begin
                        n_bad++;
                        $display("FAIL frame_addr v=%0d h=%0d got %0d want %0d",
                                 vv, 56 + i, o_addr[i], e_addr[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0);
        p1 = 8'h00; p2 = 8'h00; p3 = 8'h00; p4 = 8'h00; p5 = 8'h00; p6 = 8'h00;
        mask = 8'h00; cmask = 8'h00; bgc = 8'h00;
        fill_mem(0);
        repeat (3) @(posedge clk);
        test_reset();
        test_backdrop();
        test_single_pixel();
        test_priority();
        test_addr_trace();
        test_cmask_zero();
        test_random();
        test_reset_midline();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
